// File: rtl/layer2_frame_ctrl.sv
// -----------------------------------------------------------------------------
// layer2_frame_ctrl
//
// Frame sequencer for the layer_2 conv stage (32 in-ch -> 64 out-ch).
// It gates an upstream pixel stream into layer_2 valid_in and counts the
// accepted input beats. It also counts valid_out_layer2 pulses and reports
// frame completion to the top-level scheduler. Data buses bypass this block
// and go straight from the source to layer_2; only control lives here.
//
// Optional feature: define L2_CTRL_TIMEOUT_EN to build a drain watchdog. When
// enabled, DRAIN aborts to DONE after DRAIN_TIMEOUT idle cycles and sets
// err_timeout. When not defined, err_timeout is tied to 0 and DRAIN waits
// indefinitely.
//
// Ports
//   clk           in   1      single clock, posedge
//   rst           in   1      asynchronous, active-high reset
//   start         in   1      begin one frame; only sampled in IDLE
//   src_valid     in   1      upstream pixel valid
//   src_ready     out  1      block accepts a pixel this cycle (FEED)
//   l2_valid_in   out  1      layer_2 valid_in (src_valid gated by FEED)
//   l2_valid_out  in   1      layer_2 valid_out_layer2
//   busy          out  1      state != IDLE
//   done          out  1      one-cycle pulse while in DONE
//   in_cnt        out  CNT_W  accepted input beats this frame
//   out_cnt       out  CNT_W  output pulses, saturating at OUT_PIXELS
//   err_extra     out  1      sticky: pulse seen with out_cnt == OUT_PIXELS
//   err_timeout   out  1      sticky: drain watchdog expired
// -----------------------------------------------------------------------------
module layer2_frame_ctrl #(
  parameter int unsigned FRAME_PIXELS  = 220,
  parameter int unsigned OUT_PIXELS    = 196,
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             l2_valid_in,
  input  logic             l2_valid_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] in_cnt,
  output logic [CNT_W-1:0] out_cnt,
  output logic             err_extra,
  output logic             err_timeout
);

  // Counters never wrap: every limit must fit in CNT_W bits and be non-zero.
  if (CNT_W < 1 || CNT_W > 32 ||
      FRAME_PIXELS == 0 || (FRAME_PIXELS >> CNT_W) != 0 ||
      OUT_PIXELS == 0 || (OUT_PIXELS >> CNT_W) != 0 ||
      DRAIN_TIMEOUT == 0 || (DRAIN_TIMEOUT >> CNT_W) != 0) begin : g_param_err
    $error("layer2_frame_ctrl: FRAME_PIXELS/OUT_PIXELS/DRAIN_TIMEOUT out of CNT_W range");
  end

  localparam logic [CNT_W-1:0] InLast  = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [CNT_W-1:0] OutFull = CNT_W'(OUT_PIXELS);
  localparam logic [CNT_W-1:0] OutLast = CNT_W'(OUT_PIXELS - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StDrain,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             err_extra_q, err_extra_d;

  logic beat;
  logic out_counting;
  logic out_full;
  logic out_last_hit;

  // Handshake outputs are decoded straight from the state register, so they
  // drop in the same cycle as an asynchronous reset.
  assign src_ready   = (state_q == StFeed);
  assign l2_valid_in = src_ready & src_valid;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);

  assign beat         = src_ready & src_valid;
  assign out_counting = (state_q == StFeed) || (state_q == StDrain);
  assign out_full     = (out_cnt_q == OutFull);
  assign out_last_hit = (out_cnt_q == OutLast) & l2_valid_out;

`ifdef L2_CTRL_TIMEOUT_EN
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             err_timeout_q, err_timeout_d;
  logic             wdog_expire;

  localparam logic [CNT_W-1:0] WdogLast = CNT_W'(DRAIN_TIMEOUT - 1);

  // Counts consecutive DRAIN cycles without an output pulse.
  assign wdog_expire = (state_q == StDrain) && !l2_valid_out && (wdog_q == WdogLast);

  always_comb begin
    wdog_d = '0;
    if ((state_q == StDrain) && !l2_valid_out) begin
      wdog_d = wdog_q + CntOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  // Next-state and counter logic.
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    err_extra_d = err_extra_q;
`ifdef L2_CTRL_TIMEOUT_EN
    err_timeout_d = err_timeout_q;
`endif

    // Output pulses count in FEED and DRAIN only; out_cnt saturates and any
    // surplus pulse is flagged instead.
    if (out_counting && l2_valid_out) begin
      if (out_full) begin
        err_extra_d = 1'b1;
      end else begin
        out_cnt_d = out_cnt_q + CntOne;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StFeed;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          err_extra_d = 1'b0;
`ifdef L2_CTRL_TIMEOUT_EN
          err_timeout_d = 1'b0;
`endif
        end
      end
      StFeed: begin
        if (beat) begin
          in_cnt_d = in_cnt_q + CntOne;
          if (in_cnt_q == InLast) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (out_full || out_last_hit) begin
          state_d = StDone;
        end
`ifdef L2_CTRL_TIMEOUT_EN
        else if (wdog_expire) begin
          state_d       = StDone;
          err_timeout_d = 1'b1;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      err_extra_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      err_extra_q <= err_extra_d;
    end
  end

  assign in_cnt    = in_cnt_q;
  assign out_cnt   = out_cnt_q;
  assign err_extra = err_extra_q;

endmodule
